pipe_stall_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage MiniMIPS32 core. It produces per-stage stall and bubble controls for the PC, IF/ID, ID/EXE and EXE/MEM registers. It has two sources of stalls:
- load-use hazards between the ID stage and a load in EXE;
- a fixed-latency multi-cycle divider, which it starts and counts out while EXE is held.
It sits beside the pipeline registers and drives their hold and flush inputs.

---
 rtl/pipe_stall_ctrl_pkg.sv | 26 ++
 rtl/pipe_stall_ctrl_load_use.sv | 18 +
 rtl/pipe_stall_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the MiniMIPS32 pipeline stall/sequencing controller.
package pipe_stall_ctrl_pkg;

  localparam int unsigned STALL_BUS    = 4;
  localparam int unsigned STALL_PC     = 0;
  localparam int unsigned STALL_IFID   = 1;
  localparam int unsigned STALL_IDEXE  = 2;
  localparam int unsigned STALL_EXEMEM = 3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV_RUN  = 2'd1,
    S_DIV_DONE = 2'd2
  } state_t;

  // Hold enables for every stage from the PC up to and including top_idx.
  function automatic logic [STALL_BUS-1:0] stall_upto(input int unsigned top_idx);
    logic [STALL_BUS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < STALL_BUS; i++) begin
      if (i <= top_idx) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_load_use.sv
// Combinational load-use hazard detector: a load in EXE feeding a source read in ID.
module load_use_detect (
  input  logic       exe_mreg,
  input  logic       exe_wreg,
  input  logic [4:0] exe_wa,
  input  logic       id_re1,
  input  logic       id_re2,
  input  logic [4:0] id_ra1,
  input  logic [4:0] id_ra2,
  output logic       hazard
);

  always_comb begin
    hazard = exe_mreg & exe_wreg & (exe_wa != '0) &
             ((id_re1 & (id_ra1 == exe_wa)) | (id_re2 & (id_ra2 == exe_wa)));
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/bubble controller: load-use interlock plus fixed-latency divider sequencing.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 cpu_clk_50M,
  input  logic                 cpu_rst_n,
  input  logic                 flush,
  input  logic                 exe_div_req,
  input  logic                 exe_mreg,
  input  logic                 exe_wreg,
  input  logic [4:0]           exe_wa,
  input  logic                 id_re1,
  input  logic                 id_re2,
  input  logic [4:0]           id_ra1,
  input  logic [4:0]           id_ra2,
  output logic [STALL_BUS-1:0] stall,
  output logic                 flush_idexe,
  output logic                 flush_exemem,
  output logic                 div_start,
  output logic                 div_done,
  output logic                 div_busy,
  output logic [31:0]          stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_INIT = (DIV_CYCLES > 1) ? CNT_W'(DIV_CYCLES - 2) : '0;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [31:0]          stall_cycles_q;
  logic                 hazard;
  logic [STALL_BUS-1:0] stall_c;
  logic                 flush_idexe_c, flush_exemem_c, div_start_c, div_done_c, div_busy_c;

  load_use_detect u_load_use_detect (
    .exe_mreg (exe_mreg),
    .exe_wreg (exe_wreg),
    .exe_wa   (exe_wa),
    .id_re1   (id_re1),
    .id_re2   (id_re2),
    .id_ra1   (id_ra1),
    .id_ra2   (id_ra2),
    .hazard   (hazard)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_c        = '0;
    flush_idexe_c  = 1'b0;
    flush_exemem_c = 1'b0;
    div_start_c    = 1'b0;
    div_done_c     = 1'b0;
    div_busy_c     = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (exe_div_req) begin
            div_start_c    = 1'b1;
            stall_c        = stall_upto(STALL_IDEXE);
            flush_exemem_c = 1'b1;
            if (DIV_CYCLES == 1) begin
              state_d = S_DIV_DONE;
            end else begin
              state_d = S_DIV_RUN;
              cnt_d   = CNT_INIT;
            end
          end else if (hazard) begin
            stall_c       = stall_upto(STALL_IFID);
            flush_idexe_c = 1'b1;
          end
        end
        S_DIV_RUN: begin
          stall_c        = stall_upto(STALL_IDEXE);
          flush_exemem_c = 1'b1;
          div_busy_c     = 1'b1;
          if (cnt_q == '0) state_d = S_DIV_DONE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        S_DIV_DONE: begin
          div_done_c = 1'b1;
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n)                          stall_cycles_q <= '0;
    else if ((|stall) && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
  end

  // Controls are decoded partly from live inputs, so gate them to keep everything quiet in reset.
  always_comb begin
    stall        = cpu_rst_n ? stall_c        : '0;
    flush_idexe  = cpu_rst_n & flush_idexe_c;
    flush_exemem = cpu_rst_n & flush_exemem_c;
    div_start    = cpu_rst_n & div_start_c;
    div_done     = cpu_rst_n & div_done_c;
    div_busy     = cpu_rst_n & div_busy_c;
    stall_cycles = stall_cycles_q;
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (DIV_CYCLES=32 and DIV_CYCLES=1 builds).
module tb_pipe_stall_ctrl;

  logic cpu_clk_50M = 1'b0;
  always #10 cpu_clk_50M = ~cpu_clk_50M;

  logic       cpu_rst_n, flush, exe_div_req, exe_mreg, exe_wreg, id_re1, id_re2;
  logic [4:0] exe_wa, id_ra1, id_ra2;
  logic       div_req1;

  logic [3:0]  stall0, stall1;
  logic        fi0, fe0, ds0, dd0, db0, fi1, fe1, ds1, dd1, db1;
  logic [31:0] sc0, sc1;

  pipe_stall_ctrl #(.DIV_CYCLES(32), .CNT_W(8)) dut (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n), .flush(flush),
    .exe_div_req(exe_div_req), .exe_mreg(exe_mreg), .exe_wreg(exe_wreg), .exe_wa(exe_wa),
    .id_re1(id_re1), .id_re2(id_re2), .id_ra1(id_ra1), .id_ra2(id_ra2),
    .stall(stall0), .flush_idexe(fi0), .flush_exemem(fe0), .div_start(ds0),
    .div_done(dd0), .div_busy(db0), .stall_cycles(sc0)
  );

  pipe_stall_ctrl #(.DIV_CYCLES(1), .CNT_W(8)) dut1 (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n), .flush(1'b0),
    .exe_div_req(div_req1), .exe_mreg(1'b0), .exe_wreg(1'b0), .exe_wa(5'd0),
    .id_re1(1'b0), .id_re2(1'b0), .id_ra1(5'd0), .id_ra2(5'd0),
    .stall(stall1), .flush_idexe(fi1), .flush_exemem(fe1), .div_start(ds1),
    .div_done(dd1), .div_busy(db1), .stall_cycles(sc1)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [3:0]  st;
    logic        fi, fe, ds, dd, db;
    logic [31:0] sc;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_sc[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Push the expected outputs for this cycle, sample mid-cycle, then advance to the next negedge.
  task automatic cyc(input string tag, input int sel, input logic [3:0] st,
                     input logic fi, input logic fe, input logic ds, input logic dd, input logic db);
    exp_t e;
    e.tag = tag; e.sel = sel; e.st = st;
    e.fi = fi; e.fe = fe; e.ds = ds; e.dd = dd; e.db = db;
    e.sc = exp_sc[sel];
    sb.push_back(e);
    if ((st != 4'b0) && (exp_sc[sel] != 32'hFFFF_FFFF)) exp_sc[sel] = exp_sc[sel] + 32'd1;
    #2;
    e = sb.pop_front();
    if (e.sel == 0) begin
      chk({e.tag, ".stall"}, 32'(stall0), 32'(e.st));
      chk({e.tag, ".flush_idexe"}, 32'(fi0), 32'(e.fi));
      chk({e.tag, ".flush_exemem"}, 32'(fe0), 32'(e.fe));
      chk({e.tag, ".div_start"}, 32'(ds0), 32'(e.ds));
      chk({e.tag, ".div_done"}, 32'(dd0), 32'(e.dd));
      chk({e.tag, ".div_busy"}, 32'(db0), 32'(e.db));
      chk({e.tag, ".stall_cycles"}, sc0, e.sc);
    end else begin
      chk({e.tag, ".stall"}, 32'(stall1), 32'(e.st));
      chk({e.tag, ".flush_idexe"}, 32'(fi1), 32'(e.fi));
      chk({e.tag, ".flush_exemem"}, 32'(fe1), 32'(e.fe));
      chk({e.tag, ".div_start"}, 32'(ds1), 32'(e.ds));
      chk({e.tag, ".div_done"}, 32'(dd1), 32'(e.dd));
      chk({e.tag, ".div_busy"}, 32'(db1), 32'(e.db));
      chk({e.tag, ".stall_cycles"}, sc1, e.sc);
    end
    @(negedge cpu_clk_50M);
  endtask

  // Expected divider pattern at cycle j of a 32-cycle divide (j=0 is the start cycle).
  task automatic div_step(input string tag, input int j);
    cyc(tag, 0, (j < 32) ? 4'b0111 : 4'b0000, 1'b0, j < 32, j == 0, j == 32, (j >= 1) && (j <= 31));
  endtask

  initial begin
    cpu_rst_n = 1'b0; flush = 1'b0; exe_div_req = 1'b0; exe_mreg = 1'b0; exe_wreg = 1'b0;
    exe_wa = 5'd0; id_re1 = 1'b0; id_re2 = 1'b0; id_ra1 = 5'd0; id_ra2 = 5'd0; div_req1 = 1'b0;
    exp_sc[0] = 32'd0; exp_sc[1] = 32'd0;
    @(negedge cpu_clk_50M);

    // Reset: active inputs must not leak through
    exe_div_req = 1'b1; exe_mreg = 1'b1; exe_wreg = 1'b1; exe_wa = 5'd8; id_re2 = 1'b1; id_ra2 = 5'd8;
    cyc("rst", 0, 4'b0, 0, 0, 0, 0, 0);
    exe_div_req = 1'b0; exe_mreg = 1'b0; exe_wreg = 1'b0; exe_wa = 5'd0; id_re2 = 1'b0; id_ra2 = 5'd0;
    cpu_rst_n = 1'b1;
    cyc("idle", 0, 4'b0, 0, 0, 0, 0, 0);

    // Single 32-cycle divide
    exe_div_req = 1'b1;
    for (int k = 0; k <= 32; k++) div_step("div", k);
    exe_div_req = 1'b0;
    cyc("div_after", 0, 4'b0, 0, 0, 0, 0, 0);

    // Load-use
    exe_mreg = 1'b1; exe_wreg = 1'b1; exe_wa = 5'd8; id_re2 = 1'b1; id_ra2 = 5'd8;
    cyc("lu_hit2", 0, 4'b0011, 1, 0, 0, 0, 0);
    exe_mreg = 1'b0;
    cyc("lu_clear", 0, 4'b0, 0, 0, 0, 0, 0);
    exe_mreg = 1'b1; exe_wa = 5'd0; id_ra2 = 5'd0;
    cyc("lu_r0", 0, 4'b0, 0, 0, 0, 0, 0);
    exe_wa = 5'd8; id_ra2 = 5'd9; id_re1 = 1'b1; id_ra1 = 5'd8;
    cyc("lu_hit1", 0, 4'b0011, 1, 0, 0, 0, 0);
    id_re1 = 1'b0;
    cyc("lu_re_off", 0, 4'b0, 0, 0, 0, 0, 0);
    exe_wreg = 1'b0; id_re1 = 1'b1;
    cyc("lu_nowreg", 0, 4'b0, 0, 0, 0, 0, 0);

    // Divide wins over a simultaneous load-use hazard; flush at T+5 aborts it
    exe_wreg = 1'b1; exe_div_req = 1'b1;
    for (int k = 0; k < 5; k++) div_step("fl_div", k);
    flush = 1'b1;
    cyc("fl_cyc", 0, 4'b0, 0, 0, 0, 0, 0);
    flush = 1'b0; exe_div_req = 1'b0; exe_mreg = 1'b0; exe_wreg = 1'b0; id_re1 = 1'b0; id_re2 = 1'b0;
    cyc("fl_idle0", 0, 4'b0, 0, 0, 0, 0, 0);
    cyc("fl_idle1", 0, 4'b0, 0, 0, 0, 0, 0);

    // Back-to-back divides: restart in the cycle after div_done
    exe_div_req = 1'b1;
    for (int k = 0; k <= 65; k++) div_step("b2b", (k < 33) ? k : k - 33);
    exe_div_req = 1'b0;
    cyc("b2b_end", 0, 4'b0, 0, 0, 0, 0, 0);

    // Reset asserted mid-cycle while in DIV_RUN with count=10
    exe_div_req = 1'b1;
    for (int k = 0; k < 21; k++) div_step("pre_rst", k);
    #5;
    cpu_rst_n = 1'b0; exp_sc[0] = 32'd0; exp_sc[1] = 32'd0;
    cyc("rst_mid", 0, 4'b0, 0, 0, 0, 0, 0);
    exe_div_req = 1'b0; cpu_rst_n = 1'b1;
    cyc("rst_rel", 0, 4'b0, 0, 0, 0, 0, 0);
    exe_div_req = 1'b1;
    cyc("rst_start", 0, 4'b0111, 0, 1, 1, 0, 0);
    flush = 1'b1;
    cyc("rst_abort", 0, 4'b0, 0, 0, 0, 0, 0);
    flush = 1'b0; exe_div_req = 1'b0;
    cyc("rst_quiet", 0, 4'b0, 0, 0, 0, 0, 0);

    // stall_cycles saturation
    exe_div_req = 1'b1;
    force dut.stall_cycles_q = 32'hFFFF_FFFD;
    exp_sc[0] = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cycles_q;
    for (int k = 0; k < 4; k++) div_step("sat", k);
    flush = 1'b1;
    cyc("sat_flush", 0, 4'b0, 0, 0, 0, 0, 0);
    flush = 1'b0; exe_div_req = 1'b0;
    cyc("sat_hold", 0, 4'b0, 0, 0, 0, 0, 0);

    // DIV_CYCLES=1 build, single and back-to-back
    div_req1 = 1'b1;
    cyc("d1_start", 1, 4'b0111, 0, 1, 1, 0, 0);
    div_req1 = 1'b0;
    cyc("d1_done", 1, 4'b0, 0, 0, 0, 1, 0);
    cyc("d1_idle", 1, 4'b0, 0, 0, 0, 0, 0);
    div_req1 = 1'b1;
    cyc("d1_b2b_s0", 1, 4'b0111, 0, 1, 1, 0, 0);
    cyc("d1_b2b_d0", 1, 4'b0, 0, 0, 0, 1, 0);
    cyc("d1_b2b_s1", 1, 4'b0111, 0, 1, 1, 0, 0);
    div_req1 = 1'b0;
    cyc("d1_b2b_d1", 1, 4'b0, 0, 0, 0, 1, 0);
    cyc("d1_end", 1, 4'b0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
